// File: rtl/caches_pkg.sv
// Shared types for the cache pair, the RAM port and the arbiter controller.
package caches_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D_RD  = 3'd1,
    D_WR  = 3'd2,
    I_RD  = 3'd3,
    ABORT = 3'd4
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_ctrl.sv
// Shares one RAM port between icache (reads) and dcache (reads/writes):
// one latched transaction at a time, bounded retry on RAM errors.
module memory_arbiter_ctrl
  import caches_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 3,
  parameter word_t       BAD_WORD  = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      iwait,
  output word_t     iload,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  output logic      load_done,
  output logic      store_done,
  output logic      bus_err
);

  localparam int unsigned RETRY_W =
    ($clog2(MAX_RETRY + 1) < 2) ? 2 : $clog2(MAX_RETRY + 1);

  arb_state_t         state_q, state_d;
  arb_state_t         op_q, op_d;
  logic               last_d_q, last_d_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  word_t              addr_q, addr_d;
  word_t              data_q, data_d;
  word_t              iload_q, iload_d;
  word_t              dload_q, dload_d;

  logic ram_ok;
  logic aborting;
  logic i_done;
  logic d_done;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      op_q     <= IDLE;
      last_d_q <= 1'b0;
      retry_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      last_d_q <= last_d_d;
      retry_q  <= retry_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
    end
  end

  // Grant, RAM sequencing and retry bookkeeping.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    last_d_d = last_d_q;
    retry_d  = retry_q;
    addr_d   = addr_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        // icache wins when the dcache had the previous grant
        if (iREN && (last_d_q || !(dWEN || dREN))) begin
          state_d  = I_RD;
          op_d     = I_RD;
          addr_d   = iaddr;
          last_d_d = 1'b0;
        end else if (dWEN) begin
          state_d  = D_WR;
          op_d     = D_WR;
          addr_d   = daddr;
          data_d   = dstore;
          last_d_d = 1'b1;
        end else if (dREN) begin
          state_d  = D_RD;
          op_d     = D_RD;
          addr_d   = daddr;
          last_d_d = 1'b1;
        end
      end
      D_RD, D_WR, I_RD: begin
        if (ramstate == ACCESS) begin
          state_d = IDLE;
          retry_d = '0;
        end else if (ramstate == ERROR) begin
          retry_d = retry_q + RETRY_W'(1);
          if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
            state_d = ABORT;
          end
        end
      end
      ABORT: begin
        retry_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Completion is combinational in the ACCESS or ABORT cycle; loads hold otherwise.
  always_comb begin
    ram_ok   = (ramstate == ACCESS);
    aborting = (state_q == ABORT);
    i_done   = ((state_q == I_RD) && ram_ok) || (aborting && (op_q == I_RD));
    d_done   = (((state_q == D_RD) || (state_q == D_WR)) && ram_ok) ||
               (aborting && ((op_q == D_RD) || (op_q == D_WR)));

    iwait      = !i_done;
    dwait      = !d_done;
    ramREN     = (state_q == D_RD) || (state_q == I_RD);
    ramWEN     = (state_q == D_WR);
    ramaddr    = (ramREN || ramWEN) ? addr_q : '0;
    ramstore   = ramWEN ? data_q : '0;
    load_done  = (state_q == D_RD) && ram_ok;
    store_done = (state_q == D_WR) && ram_ok;
    bus_err    = aborting;

    iload = iload_q;
    if (i_done) begin
      iload = aborting ? BAD_WORD : ramload;
    end
    dload = dload_q;
    if (d_done && (op_q == D_RD)) begin
      dload = aborting ? BAD_WORD : ramload;
    end
    iload_d = iload;
    dload_d = dload;
  end

endmodule

// File: tb/tb_memory_arbiter_ctrl.sv
// Directed bench for memory_arbiter_ctrl with a scoreboard of expected completions.
module tb_memory_arbiter_ctrl;
  import caches_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST = 1'b1;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      iwait, dwait, ramREN, ramWEN, load_done, store_done, bus_err;
  word_t     iload, dload, ramaddr, ramstore;

  typedef struct {
    logic  is_d;
    logic  is_wr;
    logic  err;
    word_t addr;
    word_t data;
  } exp_t;

  exp_t      sb[$];
  ramstate_t rs_q[$];
  int        n_chk  = 0;
  int        n_fail = 0;

  memory_arbiter_ctrl dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .ramload   (ramload),
    .ramstate  (ramstate),
    .iwait     (iwait),
    .iload     (iload),
    .dwait     (dwait),
    .dload     (dload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .load_done (load_done),
    .store_done(store_done),
    .bus_err   (bus_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  // Steps cycles (ramstate from rs_q, else ACCESS) until a completion, then checks it.
  task automatic run(input string tag, input int budget);
    exp_t e;
    bit   done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      ramstate = (rs_q.size() > 0) ? rs_q.pop_front() : ACCESS;
      #1;
      chk({tag, "_excl"}, word_t'(ramREN & ramWEN), 0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL %s_sb observed=empty expected=entry", tag);
        return;
      end
      e = sb[0];
      if (ramREN || ramWEN) begin
        chk({tag, "_ramaddr"}, ramaddr, e.addr);
        chk({tag, "_ramWEN"}, word_t'(ramWEN), word_t'(e.is_wr));
        chk({tag, "_ramREN"}, word_t'(ramREN), word_t'(!e.is_wr));
        if (e.is_wr) chk({tag, "_ramstore"}, ramstore, e.data);
      end
      if (bus_err || !iwait || !dwait) begin
        void'(sb.pop_front());
        done = 1'b1;
        chk({tag, "_iwait"}, word_t'(iwait), word_t'(e.is_d));
        chk({tag, "_dwait"}, word_t'(dwait), word_t'(!e.is_d));
        chk({tag, "_bus_err"}, word_t'(bus_err), word_t'(e.err));
        chk({tag, "_load_done"}, word_t'(load_done), word_t'(e.is_d && !e.is_wr && !e.err));
        chk({tag, "_store_done"}, word_t'(store_done), word_t'(e.is_d && e.is_wr && !e.err));
        if (!e.is_wr) chk({tag, "_load"}, e.is_d ? dload : iload, e.data);
      end else begin
        step();
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s_timeout observed=no_completion expected=completion", tag);
    end
  endtask

  initial begin
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    ramstate = FREE;

    // reset values
    #1 nRST = 1'b0;
    #1;
    chk("rst_iwait", word_t'(iwait), 1);
    chk("rst_dwait", word_t'(dwait), 1);
    chk("rst_strobes", word_t'({ramREN, ramWEN}), 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_loads", iload | dload, 0);
    chk("rst_pulses", word_t'({load_done, store_done, bus_err}), 0);
    step(); step();
    nRST = 1'b1;
    step();

    // 1: icache read, ACCESS after two BUSY cycles
    iREN = 1; iaddr = 32'h100; ramload = 32'hCAFE;
    sb.push_back('{1'b0, 1'b0, 1'b0, 32'h100, 32'hCAFE});
    rs_q = '{FREE, BUSY, BUSY, ACCESS};
    run("t1", 20);
    iREN = 0;
    step(); #1;
    chk("t1_iwait_once", word_t'(iwait), 1);
    chk("t1_iload_hold", iload, 32'hCAFE);

    // 3: both caches held, instant ACCESS -> D, I, D, I
    iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      ramload = 32'hA000_0000 + word_t'(k);
      sb.push_back('{(k % 2) == 0, 1'b0, 1'b0, ((k % 2) == 0) ? 32'h300 : 32'h200, ramload});
      run("t3", 20);
      if (k == 3) begin iREN = 0; dREN = 0; end
      step();
    end
    #1;
    chk("t3_iload_hold", iload, 32'hA000_0003);
    chk("t3_dload_hold", dload, 32'hA000_0002);

    // 2: dcache write
    dWEN = 1; daddr = 32'h40; dstore = 32'h1234;
    sb.push_back('{1'b1, 1'b1, 1'b0, 32'h40, 32'h1234});
    run("t2", 20);
    dWEN = 0;
    step();

    // 4: read and write both requested -> write only
    dREN = 1; dWEN = 1; daddr = 32'h44; dstore = 32'h5678;
    sb.push_back('{1'b1, 1'b1, 1'b0, 32'h44, 32'h5678});
    rs_q = '{FREE, BUSY, ACCESS};
    run("t4", 20);
    dREN = 0; dWEN = 0;
    step(); #1;
    chk("t4_dload_hold", dload, 32'hA000_0002);

    // 5: three ERRORs abort the dcache read
    dREN = 1; daddr = 32'h80; ramload = 32'h5555;
    sb.push_back('{1'b1, 1'b0, 1'b1, 32'h80, 32'hBAD1BAD1});
    rs_q = '{FREE, ERROR, ERROR, ERROR};
    run("t5", 20);
    dREN = 0;
    step(); #1;
    chk("t5_bus_err_pulse", word_t'(bus_err), 0);
    chk("t5_dload_hold", dload, 32'hBAD1BAD1);

    // two ERRORs stay below the abort threshold
    dREN = 1; daddr = 32'h84; ramload = 32'h77;
    sb.push_back('{1'b1, 1'b0, 1'b0, 32'h84, 32'h77});
    rs_q = '{FREE, ERROR, ERROR, ACCESS};
    run("t5b", 20);
    dREN = 0;
    step();

    // 6: async reset during a BUSY write
    dWEN = 1; daddr = 32'h60; dstore = 32'h9; ramstate = FREE;
    step();
    ramstate = BUSY;
    #1;
    chk("t6_ramWEN_pre", word_t'(ramWEN), 1);
    nRST = 1'b0;
    #1;
    chk("t6_ramWEN_rst", word_t'(ramWEN), 0);
    chk("t6_ramaddr_rst", ramaddr, 0);
    chk("t6_ramstore_rst", ramstore, 0);
    chk("t6_dwait_rst", word_t'(dwait), 1);
    chk("t6_dload_rst", dload, 0);
    dWEN = 0;
    step(); step();
    nRST = 1'b1;
    step(); #1;
    chk("t6_idle_strobes", word_t'({ramREN, ramWEN}), 0);
    iREN = 1; iaddr = 32'h10; ramload = 32'h42;
    sb.push_back('{1'b0, 1'b0, 1'b0, 32'h10, 32'h42});
    run("t6_after", 20);
    iREN = 0;
    step();

    chk("sb_drained", word_t'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
